sync_filter_array: RTL
======================

SYNC_FILTER_ARRAY -- requirements
Module: sync_filter_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent single-bit asynchronous inputs, range 1..64.
REQ-002 Parameter STAGES, default 3: synchronizer flip-flop depth per channel, range 2..6.
REQ-003 Parameter FILTER_CYCLES, default 0: glitch-filter length in dest_clk cycles; 0 means filter bypassed, range 0..255.
REQ-004 Parameter RESET_VAL, default all-zeros, CHANNELS bits: per-channel reset level of every register.
REQ-005 dest_clk  input  1  destination clock; all state is clocked on its rising edge.
REQ-006 dest_rst  input  1  asynchronous, active-high reset.
REQ-007 async_in  input  CHANNELS  asynchronous level inputs, one bit per channel.
REQ-008 sync_out  output  CHANNELS  synchronized and filtered levels.
REQ-009 rise_pulse  output  CHANNELS  one-cycle pulse when sync_out[i] goes 0->1.
REQ-010 fall_pulse  output  CHANNELS  one-cycle pulse when sync_out[i] goes 1->0.
REQ-011 change_any  output  1  OR of all rise_pulse and fall_pulse bits, same cycle.

Function
REQ-012 Each channel SHALL pass async_in[i] through a chain of exactly STAGES flip-flops; the last stage is the synchronized value s[i].
REQ-013 With FILTER_CYCLES=0, sync_out[i] SHALL equal s[i], giving STAGES-edge latency from a stable async_in change.
REQ-014 With FILTER_CYCLES>0, each channel SHALL hold a counter cnt[i] of width clog2(FILTER_CYCLES+1).
REQ-015 Filter rule per edge: if s[i]==sync_out[i], cnt[i]<=0.
REQ-016 Filter rule per edge: if s[i]!=sync_out[i] and cnt[i]==FILTER_CYCLES-1, sync_out[i]<=s[i] and cnt[i]<=0.
REQ-017 Filter rule per edge: otherwise cnt[i]<=cnt[i]+1.
REQ-018 Total filtered latency from a stable input change SHALL be STAGES+FILTER_CYCLES edges.
REQ-019 A change in s[i] that lasts fewer than FILTER_CYCLES cycles SHALL NOT alter sync_out[i] and SHALL NOT produce a pulse.
REQ-020 The counter SHALL never wrap; it SHALL saturate at FILTER_CYCLES-1 only transiently before the update.
REQ-021 rise_pulse/fall_pulse SHALL be registered, asserted in the first cycle sync_out[i] shows the new level, and high for exactly one cycle.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 No combinational path SHALL exist from async_in to any output.

Reset
REQ-024 dest_rst assertion SHALL immediately set all synchronizer stages and sync_out to RESET_VAL and set all cnt to 0.
REQ-025 During and after reset, rise_pulse, fall_pulse and change_any SHALL be 0; the first post-reset cycle SHALL NOT generate a pulse.
REQ-026 Reset asserted mid-filter SHALL discard the partial count; filtering restarts from 0 after release.
REQ-027 Reset release is assumed synchronized to dest_clk externally; the block contains no reset synchronizer.

Structure
REQ-028 A shared package cdc_pkg SHALL hold the clog2 function, MIN_STAGES=2 and MAX_STAGES=6 constants.
REQ-029 Elaboration SHALL fail on STAGES outside MIN_STAGES..MAX_STAGES or CHANNELS outside 1..64.
REQ-030 One sub-module sync_filter_chan (one channel: chain, filter, edge detect) SHALL be instantiated CHANNELS times by a generate loop; change_any is formed at top level.
REQ-031 Synchronizer flops SHALL carry the project's async-register/no-retime attribute.

Verification
REQ-032 STAGES=3, FILTER_CYCLES=0, async_in[0] 0->1 held: sync_out[0]=1 on 3rd edge, rise_pulse[0] and change_any high for 1 cycle.
REQ-033 STAGES=2, FILTER_CYCLES=4: 3-cycle high glitch on async_in[1] -> sync_out[1] stays 0, no pulse; 10-cycle high -> sync_out[1]=1 on edge 6, rise_pulse[1] once.
REQ-034 CHANNELS=4, async_in 0000->1111 and later 1111->0000 in one cycle -> all four rise (then fall) pulses asserted in the same cycle, change_any one cycle.
REQ-035 RESET_VAL=4'b1010, dest_rst pulse then async_in=1010: sync_out=1010 immediately on reset, no pulses ever.
REQ-036 FILTER_CYCLES=8, dest_rst asserted at cnt=5 with input held changed: outputs return to RESET_VAL; after release update occurs STAGES+8 edges later.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared CDC constants and helpers used by the synchronizer/filter blocks.
package cdc_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 6;

  // Ceiling log2; clog2(1) is 0, so callers must guard against zero-width results.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchronizer, optional glitch filter, registered edge pulses.
module sync_filter_chan
  import cdc_pkg::*;
#(
  parameter int   STAGES        = 3,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  (* ASYNC_REG = "TRUE", DONT_RETIME = "TRUE" *) logic [STAGES-1:0] chain_reg;
  logic sync_level;
  logic update;
  logic new_level;
  logic rise_reg;
  logic fall_reg;

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) chain_reg <= {STAGES{RESET_VAL}};
    else          chain_reg <= {chain_reg[STAGES-2:0], async_in};
  end

  assign sync_level = chain_reg[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      // Look one stage ahead so the pulse register lands in the same cycle as the output.
      assign sync_out  = sync_level;
      assign update    = chain_reg[STAGES-2] != sync_level;
      assign new_level = chain_reg[STAGES-2];
    end else begin : g_filter
      localparam int CW = clog2(FILTER_CYCLES + 1);
      logic          out_reg;
      logic [CW-1:0] cnt_reg;

      assign update    = (sync_level != out_reg) && (cnt_reg == CW'(FILTER_CYCLES - 1));
      assign new_level = sync_level;
      assign sync_out  = out_reg;

      always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
          out_reg <= RESET_VAL;
          cnt_reg <= '0;
        end else if (sync_level == out_reg) begin
          cnt_reg <= '0;
        end else if (update) begin
          out_reg <= sync_level;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= update & new_level;
      fall_reg <= update & ~new_level;
    end
  end

  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule

// File: rtl/sync_filter_array.sv
// Array of independent single-bit synchronizers with glitch filter and edge pulses.
module sync_filter_array
  import cdc_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  STAGES        = 3,
  parameter int                  FILTER_CYCLES = 0,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                dest_clk,
  input  logic                dest_rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                change_any
);

  generate
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("sync_filter_array: STAGES out of range");
    end
    if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
      $error("sync_filter_array: CHANNELS out of range");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
      $error("sync_filter_array: FILTER_CYCLES out of range");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      sync_filter_chan #(
        .STAGES       (STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .RESET_VAL    (RESET_VAL[gi])
      ) u_chan (
        .dest_clk  (dest_clk),
        .dest_rst  (dest_rst),
        .async_in  (async_in[gi]),
        .sync_out  (sync_out[gi]),
        .rise_pulse(rise_pulse[gi]),
        .fall_pulse(fall_pulse[gi])
      );
    end
  endgenerate

  assign change_any = |(rise_pulse | fall_pulse);

endmodule
